// File: rtl/set_bit_enc_pkg.sv
// Shared definitions for the set-bit encoder.
// Holds the default vector width, the index width derived from it, and the
// two-state control enum used by the top-level sequencer.
package set_bit_enc_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = $clog2(DEF_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   i_mask  WIDTH-bit mask to search
//   o_idx   binary index of the lowest set bit (0 when the mask is empty)
//   o_none  1 when no bit of the mask is set
module lsb_priority_enc #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_none
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx  = IDX_W'(i);
        o_none = 1'b0;
      end else begin
        o_idx  = o_idx;
        o_none = o_none;
      end
    end
  end

endmodule

// File: rtl/set_bit_encoder.sv
// Sequential multi-hot to binary encoder.
// Accepts a WIDTH-bit vector over a valid/ready handshake, then emits the
// binary index of every set bit, lowest first, one per output handshake.
// An all-zero vector produces a single beat flagged with o_out_empty.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   input vector valid
//   o_in_ready   block can accept a vector
//   i_in_vec     vector to encode
//   o_out_valid  output beat valid
//   i_out_ready  downstream accepts the current beat
//   o_out_idx    index of the current set bit
//   o_out_last   current beat is the final one for this vector
//   o_out_empty  accepted vector was all-zero
module set_bit_encoder
  import set_bit_enc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_vec,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [IDX_W-1:0] o_out_idx,
  output logic             o_out_last,
  output logic             o_out_empty
);

  state_e           r_state;
  logic [WIDTH-1:0] r_pending;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;
  logic             r_out_empty;

  logic [WIDTH-1:0] w_cur_bit;
  logic [WIDTH-1:0] w_next_mask;
  logic [IDX_W-1:0] w_idx;
  logic             w_none;
  logic             w_next_single;

  // Mask the encoder will search for the beat after the next edge:
  // the fresh vector while idle, the pending mask minus the current bit
  // while emitting.
  always_comb begin
    w_cur_bit   = WIDTH'(1'b1) << r_out_idx;
    w_next_mask = '0;
    case (r_state)
      IDLE:    w_next_mask = i_in_vec;
      EMIT:    w_next_mask = r_pending & ~w_cur_bit;
      default: w_next_mask = '0;
    endcase
  end

  // Exactly one bit remains when clearing the lowest bit leaves nothing.
  assign w_next_single = (w_next_mask != '0) &&
                         ((w_next_mask & (w_next_mask - WIDTH'(1'b1))) == '0);

  lsb_priority_enc #(
    .WIDTH (WIDTH)
  ) u_lsb_enc (
    .i_mask (w_next_mask),
    .o_idx  (w_idx),
    .o_none (w_none)
  );

  // Control sequencer with registered handshake and beat outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_empty <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_state     <= EMIT;
            r_pending   <= i_in_vec;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            if (w_none) begin
              r_out_idx   <= '0;
              r_out_last  <= 1'b1;
              r_out_empty <= 1'b1;
            end else begin
              r_out_idx   <= w_idx;
              r_out_last  <= w_next_single;
              r_out_empty <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        EMIT: begin
          if (i_out_ready) begin
            if (r_out_last) begin
              r_state     <= IDLE;
              r_pending   <= '0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_idx   <= '0;
              r_out_last  <= 1'b0;
              r_out_empty <= 1'b0;
            end else begin
              r_pending  <= w_next_mask;
              r_out_idx  <= w_idx;
              r_out_last <= w_next_single;
            end
          end else begin
            r_state <= EMIT;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_pending   <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_idx   <= '0;
          r_out_last  <= 1'b0;
          r_out_empty <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_idx   = r_out_idx;
  assign o_out_last  = r_out_last;
  assign o_out_empty = r_out_empty;

endmodule

// File: tb/tb_set_bit_encoder.sv
// Self-checking bench for set_bit_encoder: table of vectors drained with
// continuous out_ready, plus reset, backpressure and mid-emission reset
// sequences.
module tb_set_bit_encoder;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_vec;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [2:0] o_out_idx;
  logic       o_out_last;
  logic       o_out_empty;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [7:0]      vec;
    logic [3:0]      n;
    logic [7:0][2:0] idx;
    logic            empty;
  } vec_t;

  vec_t tbl [12];

  set_bit_encoder dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_vec    (i_in_vec),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_idx   (o_out_idx),
    .o_out_last  (o_out_last),
    .o_out_empty (o_out_empty)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present one vector for one handshake.
  task automatic send(input logic [7:0] v);
    int guard;
    guard = 0;
    while (!o_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("send_in_ready", 32'(o_in_ready), 32'd1);
    check("pre_out_valid", 32'(o_out_valid), 32'd0);
    i_in_valid = 1'b1;
    i_in_vec   = v;
    tick();
    i_in_valid = 1'b0;
    i_in_vec   = 8'h5A;
    check("latency_out_valid", 32'(o_out_valid), 32'd1);
  endtask

  // Send a table entry and drain it with out_ready held high.
  task automatic run_vec(input vec_t v);
    i_out_ready = 1'b1;
    send(v.vec);
    for (int b = 0; b < int'(v.n); b++) begin
      check("beat_valid", 32'(o_out_valid), 32'd1);
      check("beat_idx", 32'(o_out_idx), 32'(v.idx[b]));
      check("beat_last", 32'(o_out_last), (b == int'(v.n) - 1) ? 32'd1 : 32'd0);
      check("beat_empty", 32'(o_out_empty), 32'(v.empty));
      check("beat_in_ready", 32'(o_in_ready), 32'd0);
      tick();
    end
    check("done_out_valid", 32'(o_out_valid), 32'd0);
    check("done_in_ready", 32'(o_in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] pat;
    logic       prev_stall;
    logic [2:0] prev_idx;
    logic       prev_last;
    int         e;
    int         c;
    logic       done;

    n_checks = 0;
    n_fail   = 0;

    // One-hot vectors 0..7
    for (int i = 0; i < 8; i++) begin
      tbl[i]        = '0;
      tbl[i].vec    = 8'h01 << i;
      tbl[i].n      = 4'd1;
      tbl[i].idx[0] = 3'(i);
    end
    // Multi-hot 1010_0110 -> 1,2,5,7
    tbl[8]        = '0;
    tbl[8].vec    = 8'b1010_0110;
    tbl[8].n      = 4'd4;
    tbl[8].idx[0] = 3'd1;
    tbl[8].idx[1] = 3'd2;
    tbl[8].idx[2] = 3'd5;
    tbl[8].idx[3] = 3'd7;
    // Zero vector -> single empty beat
    tbl[9]        = '0;
    tbl[9].vec    = 8'h00;
    tbl[9].n      = 4'd1;
    tbl[9].empty  = 1'b1;
    // Both ends -> 0,7
    tbl[10]        = '0;
    tbl[10].vec    = 8'h81;
    tbl[10].n      = 4'd2;
    tbl[10].idx[0] = 3'd0;
    tbl[10].idx[1] = 3'd7;
    // All ones -> 0..7
    tbl[11]     = '0;
    tbl[11].vec = 8'hFF;
    tbl[11].n   = 4'd8;
    for (int i = 0; i < 8; i++) tbl[11].idx[i] = 3'(i);

    // Reset with a valid vector pending: nothing may be accepted.
    i_rst_n     = 1'b0;
    i_in_valid  = 1'b1;
    i_in_vec    = 8'hFF;
    i_out_ready = 1'b1;
    tick();
    tick();
    i_rst_n    = 1'b1;
    i_in_valid = 1'b0;
    check("rst_in_ready", 32'(o_in_ready), 32'd1);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_out_idx", 32'(o_out_idx), 32'd0);
    check("rst_out_last", 32'(o_out_last), 32'd0);
    check("rst_out_empty", 32'(o_out_empty), 32'd0);
    tick();
    check("rst_after_out_valid", 32'(o_out_valid), 32'd0);

    for (int k = 0; k < 12; k++) run_vec(tbl[k]);

    // Backpressure on 8'hFF, out_ready pattern 1,0,0,1 repeating, with a
    // competing vector presented during emission.
    pat        = 4'b1001;
    i_out_ready = 1'b1;
    send(8'hFF);
    i_in_valid = 1'b1;
    i_in_vec   = 8'h0F;
    e          = 0;
    c          = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_idx   = 3'd0;
    prev_last  = 1'b0;
    while (!done && c < 100) begin
      check("bp_in_ready", 32'(o_in_ready), 32'd0);
      check("bp_out_valid", 32'(o_out_valid), 32'd1);
      if (prev_stall) begin
        check("bp_hold_idx", 32'(o_out_idx), 32'(prev_idx));
        check("bp_hold_last", 32'(o_out_last), 32'(prev_last));
      end
      i_out_ready = pat[c % 4];
      if (i_out_ready && o_out_valid) begin
        check("bp_idx", 32'(o_out_idx), 32'(e));
        check("bp_last", 32'(o_out_last), (e == 7) ? 32'd1 : 32'd0);
        check("bp_empty", 32'(o_out_empty), 32'd0);
        if (o_out_last) done = 1'b1;
        e++;
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_idx   = o_out_idx;
      prev_last  = o_out_last;
      c++;
      tick();
    end
    i_in_valid = 1'b0;
    check("bp_done", 32'(done), 32'd1);
    check("bp_beats", 32'(e), 32'd8);
    check("bp_end_out_valid", 32'(o_out_valid), 32'd0);
    check("bp_end_in_ready", 32'(o_in_ready), 32'd1);
    tick();
    check("bp_ignored_vec", 32'(o_out_valid), 32'd0);

    // Reset mid-emission of 8'hF0 after two beats.
    i_out_ready = 1'b1;
    send(8'hF0);
    check("mr_beat0", 32'(o_out_idx), 32'd4);
    tick();
    check("mr_beat1", 32'(o_out_idx), 32'd5);
    tick();
    check("mr_beat2", 32'(o_out_idx), 32'd6);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check("mr_out_valid", 32'(o_out_valid), 32'd0);
    check("mr_in_ready", 32'(o_in_ready), 32'd1);
    check("mr_out_idx", 32'(o_out_idx), 32'd0);
    tick();
    check("mr_no_partial", 32'(o_out_valid), 32'd0);
    run_vec(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/set_bit_encoder.md
Name: set_bit_encoder

Overview:
Sequential one-hot/multi-hot to binary encoder, the inverse of the 3-to-8 binary decoder. Accepts a WIDTH-bit vector over a valid/ready input handshake, then emits the binary index of every set bit, LSB first, one index per output handshake, with a last-beat flag. Used wherever decoded select or request lines must be turned back into compact binary codes.

Parameters:
WIDTH, 8, width of input vector; power of two, >= 2
IDX_W, $clog2(WIDTH) (3 at default), width of emitted index; derived, never overridden

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_vec is valid
in_ready  output  1  block can accept a vector
in_vec  input  WIDTH  vector to encode
out_valid  output  1  out_idx/out_last/out_empty valid
out_ready  input  1  downstream accepts current beat
out_idx  output  IDX_W  binary index of current set bit
out_last  output  1  current beat is the final beat for this vector
out_empty  output  1  accepted vector was all-zero; out_idx is 0 and carries no information

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, pending=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_empty=0. Reset takes priority over any handshake in the same cycle. Reset mid-emission drops all remaining beats; no partial beat survives.
- States: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0. Input handshake (in_valid & in_ready) moves to EMIT on the next edge:
  - in_vec != 0: pending <= in_vec; out_idx <= index of lowest set bit; out_last <= (popcount(in_vec)==1); out_empty <= 0.
  - in_vec == 0: pending <= 0; out_idx <= 0; out_last <= 1; out_empty <= 1.
- Latency: out_valid=1 in the cycle after the input handshake.
- EMIT: in_ready=0, out_valid=1. out_idx, out_last and out_empty are registered and held stable while out_ready=0; no combinational path from out_ready to any output.
- Output handshake (out_valid & out_ready) with out_last=0: clear the bit at out_idx in pending; out_idx <= lowest set bit of the cleared mask; out_last <= (exactly one bit remains). Next beat is valid in the very next cycle, so throughput is one index per cycle under continuous out_ready.
- Output handshake with out_last=1: state <= IDLE, pending <= 0, out_valid <= 0, out_last <= 0, out_empty <= 0. in_ready is 1 in the following cycle, giving one idle bubble between vectors.
- Beat count per vector = popcount(in_vec), or 1 if in_vec == 0. Indices are strictly increasing within a vector.
- in_vec is sampled only at the input handshake; changes to it during EMIT are ignored.
- in_valid while in_ready=0 has no effect; the upstream must hold it.
- All-ones vector: WIDTH beats, indices 0..WIDTH-1, last beat index WIDTH-1.
- Only bit WIDTH-1 set: single beat, out_idx = WIDTH-1 (all ones), out_last=1.

Decomposition:
- Shared package set_bit_enc_pkg: WIDTH default and IDX_W localparam, EMIT/IDLE state enum typedef.
- Sub-module lsb_priority_enc: combinational, WIDTH-bit mask in -> IDX_W index of lowest set bit plus a 'none' flag. Instantiate it once, driven by the next-pending mask, so the result can be registered into out_idx.
- Compute the out_last condition as (mask & (mask-1)) == 0 with mask != 0; no popcount adder is required.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and in_vec=8'hFF -> in_ready=1, out_valid=0, out_idx=0 after release; nothing is accepted during reset.
- Exhaustive one-hot: for i=0..7 send in_vec=8'b1<<i with out_ready=1 -> exactly one beat per vector, out_idx=i, out_last=1, out_empty=0, out_valid asserted 1 cycle after acceptance.
- Multi-hot: in_vec=8'b1010_0110 with out_ready=1 -> beats out_idx=1,2,5,7 on consecutive cycles; out_last=1 only on idx 7; in_ready returns to 1 on the cycle after the idx-7 beat.
- Zero vector: in_vec=8'h00 -> single beat with out_empty=1, out_last=1, out_idx=0.
- Backpressure: in_vec=8'hFF with out_ready toggling 1,0,0,1,... -> indices 0..7 in order, no beat duplicated or skipped, outputs stable while out_ready=0, in_ready=0 throughout; a new in_vec applied mid-emission is ignored.
- Reset mid-emission: in_vec=8'hF0, accept 2 beats, pulse rst_n=0 for 1 cycle -> out_valid=0 next cycle, in_ready=1; a subsequent in_vec=8'h01 yields a single beat with idx 0.
